// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential MIPS fetch front end. It holds the PC and fetches one instruction
//   at a time over a req/gnt/rvalid handshake. The instruction is held for decode, and the next
//   PC is formed from the branch and jump resolution that decode returns.
// Latency: 3 cycles per instruction with zero-wait memory (FETCH, WAIT, ISSUE). Each grant, response
//   or decode stall cycle adds one cycle.
// Backpressure: imem_req is held until imem_gnt. instr/instr_valid are held until instr_ready.
//   Only one fetch is outstanding at a time.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   imem_req/addr/gnt          fetch request channel (addr stable while req)
//   imem_rvalid/rdata          fetch response channel (accepted only in WAIT)
//   instr_valid/ready          decode handshake; instr, instr_pc, operation, func presented
//   pc_src, jump, jr_target    next-PC resolution, sampled on the decode handshake edge
//   fetch_err                  one-cycle pulse after an illegal jump or a misaligned jr target
// Optional build macro IFETCH_PERF_EN adds perf_instr_cnt / perf_stall_cnt (32-bit, wrapping).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_stall_cnt,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [5:0]  operation,
  output logic [5:0]  func,
  input  logic        pc_src,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        err_q, err_d;

  logic [31:0] p4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        next_err;
  logic        issue_fire;

  assign issue_fire = (state_q == S_ISSUE) && instr_ready;

  // Next-PC resolution. A jump overrides a taken branch. An illegal jump
  // falls through to p4 so fetch keeps making progress, and fetch_err flags it.
  assign p4     = ipc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    next_pc  = p4;
    next_err = 1'b0;
    case (jump)
      2'b01: next_pc = {p4[31:28], instr_q[25:0], 2'b00};
      2'b10: begin
        next_pc  = {jr_target[31:2], 2'b00};
        next_err = (jr_target[1:0] != 2'b00);
      end
      2'b11: begin
        next_pc  = p4;
        next_err = 1'b1;
      end
      default: begin
        if (pc_src) next_pc = p4 + br_off;
        else        next_pc = p4;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          pc_d    = next_pc;
          err_d   = next_err;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      err_q   <= err_d;
    end
  end

  // The PC register is the fetch address. It only changes on the ISSUE
  // handshake, so it is stable for the whole time the request is pending.
  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_err   = err_q;
  assign operation   = instr_q[31:26];
  assign func        = instr_q[5:0];

`ifdef IFETCH_PERF_EN
  logic        stall_cyc;
  logic [31:0] icnt_q;
  logic [31:0] scnt_q;

  assign stall_cyc = ((state_q == S_FETCH) && !imem_gnt)    ||
                     ((state_q == S_WAIT)  && !imem_rvalid) ||
                     ((state_q == S_ISSUE) && !instr_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= 32'h0;
      scnt_q <= 32'h0;
    end else begin
      if (issue_fire) icnt_q <= icnt_q + 32'd1;
      if (stall_cyc)  scnt_q <= scnt_q + 32'd1;
    end
  end

  assign perf_instr_cnt = icnt_q;
  assign perf_stall_cnt = scnt_q;
`else
  logic unused_fire;
  assign unused_fire = issue_fire;
`endif

endmodule
